// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: forward selects,
// FSM encoding and the shadow-slot record kept for EX, MEM and WB.
package hazard_ctrl_unit_pkg;

    localparam int unsigned REG_W = 4;
    localparam logic [REG_W-1:0] PC_REG = 4'd15;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_BR_FLUSH = 2'd2;

    typedef struct packed {
        logic             valid;
        logic             we;
        logic             load;
        logic [REG_W-1:0] dest;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    function automatic logic slot_match(
        input slot_t            s,
        input logic [REG_W-1:0] src,
        input logic             use_src,
        input logic [REG_W-1:0] pc_idx
    );
        return s.valid & s.we & use_src & (s.dest == src) & (src != pc_idx);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Priority match of one source register against the EX/MEM/WB shadow slots.
// A load sitting in EX cannot forward; it is reported as a load hit instead.
module fwd_select
    import hazard_ctrl_unit_pkg::*;
#(
    parameter logic [REG_W-1:0] PC_IDX = PC_REG
) (
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use,
    input  slot_t            i_ex,
    input  slot_t            i_mem,
    input  slot_t            i_wb,
    output logic [1:0]       o_sel,
    output logic             o_load_hit
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_unused_load;

    assign w_ex_hit      = slot_match(i_ex,  i_src, i_use, PC_IDX);
    assign w_mem_hit     = slot_match(i_mem, i_src, i_use, PC_IDX);
    assign w_wb_hit      = slot_match(i_wb,  i_src, i_use, PC_IDX);
    assign o_load_hit    = w_ex_hit & i_ex.load;
    assign w_unused_load = i_mem.load ^ i_wb.load;

    // Youngest producer wins.
    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit && !i_ex.load) begin
            o_sel = FWD_EX;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Decode-side hazard controller: load-use stall, branch flush, operand
// forwarding selects and saturating stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int unsigned CNT_W  = 16,
    parameter logic [3:0]  PC_REG = hazard_ctrl_unit_pkg::PC_REG
) (
    input  logic             clk,
    input  logic             R,
    input  logic             id_valid,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd_src,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic [3:0]       id_dest,
    input  logic             id_rf_we,
    input  logic             id_load,
    input  logic             branch_taken,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             if_id_flush,
    output logic             cu_nop,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import hazard_ctrl_unit_pkg::*;

    slot_t            r_ex, r_mem, r_wb;
    slot_t            w_ex_nxt;
    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_hit_a, w_hit_b, w_hit_d, w_luh;
    logic             w_pc_le, w_if_id_le, w_flush, w_nop;

    fwd_select #(.PC_IDX(PC_REG)) u_fwd_a (
        .i_src(id_rn), .i_use(id_use_rn), .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb),
        .o_sel(fwd_a), .o_load_hit(w_hit_a)
    );
    fwd_select #(.PC_IDX(PC_REG)) u_fwd_b (
        .i_src(id_rm), .i_use(id_use_rm), .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb),
        .o_sel(fwd_b), .o_load_hit(w_hit_b)
    );
    fwd_select #(.PC_IDX(PC_REG)) u_fwd_d (
        .i_src(id_rd_src), .i_use(id_use_rd), .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb),
        .o_sel(fwd_d), .o_load_hit(w_hit_d)
    );

    assign w_luh = id_valid & (w_hit_a | w_hit_b | w_hit_d);

    // LU_STALL behaves exactly like RUN; the stall has already bubbled EX.
    always_comb begin
        w_state_nxt = ST_RUN;
        w_pc_le     = 1'b1;
        w_if_id_le  = 1'b1;
        w_flush     = 1'b0;
        w_nop       = 1'b0;
        case (r_state)
            ST_BR_FLUSH: begin
            end
            default: begin
                if (w_luh) begin
                    w_pc_le     = 1'b0;
                    w_if_id_le  = 1'b0;
                    w_nop       = 1'b1;
                    w_state_nxt = ST_LU_STALL;
                end else if (branch_taken) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ST_BR_FLUSH;
                end
            end
        endcase
    end

    always_comb begin
        w_ex_nxt = SLOT_BUBBLE;
        if (!w_nop && id_valid) begin
            w_ex_nxt.valid = 1'b1;
            w_ex_nxt.we    = id_rf_we;
            w_ex_nxt.load  = id_load;
            w_ex_nxt.dest  = id_dest;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= ST_RUN;
            r_ex    <= SLOT_BUBBLE;
            r_mem   <= SLOT_BUBBLE;
            r_wb    <= SLOT_BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_ex    <= w_ex_nxt;
            r_mem   <= r_ex;
            r_wb    <= r_mem;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_nop && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign pc_le       = R & w_pc_le;
    assign if_id_le    = R & w_if_id_le;
    assign if_id_flush = R & w_flush;
    assign cu_nop      = ~R | w_nop;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    a_stall_clears_luh: assert property (
        @(posedge clk) disable iff (!R) (r_state == ST_LU_STALL) |-> !w_luh
    );

endmodule
